// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and error causes.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } lsu_state_e;

  typedef enum logic [1:0] {
    ErrNone,
    ErrSize,
    ErrAlign,
    ErrRange
  } lsu_err_e;

  // Size and alignment checks only; range depends on the instance's depth.
  function automatic lsu_err_e size_align_check(logic [1:0] size, logic [1:0] addr_lo);
    if (size == SZ_ILL) begin
      return ErrSize;
    end else if ((size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00)) begin
      return ErrAlign;
    end
    return ErrNone;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load lanes, merges store lanes into an old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] old_word_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_word_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    shifted   = load_word_i >> {offset_i, 3'b000};
    byte_lane = shifted[7:0];
    half_lane = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];

    case (size_i)
      SZ_BYTE: load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      default: load_data_o = load_word_i;
    endcase

    // Unselected lanes come straight from the old word so they stay bit-exact.
    merge_word_o = old_word_i;
    case (size_i)
      SZ_BYTE: merge_word_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
      SZ_HALF: merge_word_o[{offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      default: merge_word_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit in front of the word-addressed storage array; sub-word stores use
// a read-modify-write through RD then WR.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_datain,
  output logic              mem_str,
  output logic              mem_ld,
  input  logic [31:0]       mem_dataout
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       old_q, old_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;

  lsu_err_e    err_cause;
  logic [31:0] req_index;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  lsu_lane_align u_lane_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .offset_i    (addr_q[1:0]),
    .load_word_i (mem_dataout),
    .store_data_i(wdata_q),
    .old_word_i  (old_q),
    .load_data_o (load_data),
    .merge_word_o(merge_word)
  );

  always_comb begin
    req_index = {{(32 - ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
    err_cause = size_align_check(req_size, req_addr[1:0]);
    // Any address bit above the index field also lands outside storage.
    if (err_cause == ErrNone &&
        (req_addr[31:ADDR_W+2] != '0 || req_index >= DEPTH)) begin
      err_cause = ErrRange;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;

    req_ready   = (state_q == StIdle);
    mem_ld      = (state_q == StRd);
    mem_str     = (state_q == StWr);
    mem_address = (state_q != StIdle) ? addr_q[ADDR_W+1:2] : '0;
    mem_datain  = '0;
    if (state_q == StWr) begin
      mem_datain = (size_q == SZ_WORD) ? wdata_q : merge_word;
    end

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          if (err_cause != ErrNone) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we || req_size != SZ_WORD) begin
            state_d = StRd;
          end else begin
            state_d = StWr;
          end
        end
      end
      StRd: begin
        if (we_q) begin
          old_d   = mem_dataout;
          state_d = StWr;
        end else begin
          rdata_d      = load_data;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StWr: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed scenarios plus random traffic against a byte-level model.
module tb_lsu_mem_access;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 64;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_datain;
  logic              mem_str;
  logic              mem_ld;
  logic [31:0]       mem_dataout;

  lsu_mem_access #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_datain  (mem_datain),
    .mem_str     (mem_str),
    .mem_ld      (mem_ld),
    .mem_dataout (mem_dataout)
  );

  always #5 clk = ~clk;

  // Storage array environment: combinational read, write committed on negedge.
  logic [31:0] storage [DEPTH];
  logic        mem_fill;

  assign mem_dataout = (mem_address < ADDR_W'(DEPTH)) ? storage[mem_address[5:0]] : 32'h0;

  always @(negedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= $urandom;
    end else if (mem_str && mem_address < ADDR_W'(DEPTH)) begin
      storage[mem_address[5:0]] <= mem_datain;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Applies one request to the model; returns whether it faults and how many cycles it takes.
  task automatic ref_apply(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output int lat);
    int unsigned nbytes, idx, off;
    logic [31:0] w, val;
    nbytes = 1 << size;
    err = (size == 2'b11) || (addr % nbytes != 0) || (addr >= DEPTH * 4);
    if (err) begin
      lat = 1;
      return;
    end
    idx = addr / 4;
    off = addr % 4;
    if (we) begin
      w = ref_mem[idx];
      for (int i = 0; i < nbytes; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[idx] = w;
      lat = (nbytes == 4) ? 2 : 3;
    end else begin
      w   = ref_mem[idx];
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = w[8*(off+i) +: 8];
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
      exp_rdata = val;
      lat = 2;
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Issues one isolated request and checks latency, error flag, data and storage side effects.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic exp_err;
    int   lat, cyc;
    logic got, seen_ld, seen_str;
    @(negedge clk);
    check_val({tag, "_ready"}, req_ready, 1);
    drive(we, size, uns, addr, wdata);
    ref_apply(we, size, uns, addr, wdata, exp_err, lat);
    got = 0; cyc = 0; seen_ld = 0; seen_str = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      seen_ld  = seen_ld | mem_ld;
      seen_str = seen_str | mem_str;
      if (resp_valid) begin
        got = 1;
        cyc = c;
      end
    end
    check_val({tag, "_resp"}, got, 1);
    check_val({tag, "_lat"}, cyc, lat);
    check_val({tag, "_err"}, resp_err, exp_err);
    check_val({tag, "_rdata"}, rdata, exp_rdata);
    check_val({tag, "_ld"}, seen_ld, !exp_err && (!we || size != 2'b10));
    check_val({tag, "_str"}, seen_str, !exp_err && we);
    if (we && !exp_err) check_val({tag, "_mem"}, storage[addr[7:2]], ref_mem[addr[7:2]]);
    @(negedge clk);
    check_val({tag, "_pulse"}, {30'h0, resp_valid, resp_err}, 0);
  endtask

  initial begin
    logic [31:0] b2b_addr [3];
    logic        b2b_we   [3];
    logic [31:0] b2b_data [3];
    logic        e;
    int          l, nresp, busy_bad;
    logic [31:0] word8;

    clr_n = 1'b0;
    mem_fill = 1'b1;
    drive(0, 2'b00, 0, 0, 0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_fill = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = storage[i];
    exp_rdata = 32'h0;

    @(negedge clk);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_resp", {30'h0, resp_valid, resp_err}, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_mem_ctl", {30'h0, mem_ld, mem_str}, 0);
    check_val("rst_mem_addr", 32'(mem_address), 0);
    check_val("rst_mem_datain", mem_datain, 0);

    // Directed sequence from the block's intended use.
    do_req("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    do_req("lw10", 0, 2'b10, 0, 32'h10, 32'h0);
    check_val("lw10_val", rdata, 32'hDEADBEEF);
    do_req("sb11", 1, 2'b00, 0, 32'h11, 32'h000000AA);
    check_val("sb11_word", storage[4], 32'hDEADAAEF);
    do_req("lb11", 0, 2'b00, 0, 32'h11, 32'h0);
    check_val("lb11_val", rdata, 32'hFFFFFFAA);
    do_req("lbu11", 0, 2'b00, 1, 32'h11, 32'h0);
    check_val("lbu11_val", rdata, 32'h000000AA);
    do_req("sh12", 1, 2'b01, 0, 32'h12, 32'h00001234);
    check_val("sh12_word", storage[4], 32'h1234AAEF);
    do_req("lh12", 0, 2'b01, 0, 32'h12, 32'h0);
    check_val("lh12_val", rdata, 32'h00001234);
    do_req("lh13", 0, 2'b01, 0, 32'h13, 32'h0);
    do_req("lw100", 0, 2'b10, 0, 32'h100, 32'h0);
    do_req("szill", 0, 2'b11, 0, 32'h10, 32'h0);
    do_req("hiaddr", 1, 2'b10, 0, 32'h0001_0010, 32'h5A5A5A5A);

    // Reset asserted while a sub-word store is in its read phase.
    @(negedge clk);
    word8 = storage[8];
    drive(1, 2'b00, 0, 32'h20, 32'h00000055);
    @(posedge clk);
    #1 req_valid = 1'b0;
    clr_n = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
    exp_rdata = 32'h0;
    @(negedge clk);
    check_val("rstmid_resp", resp_valid, 0);
    check_val("rstmid_ready", req_ready, 1);
    check_val("rstmid_str", mem_str, 0);
    check_val("rstmid_word8", storage[8], word8);
    check_val("rstmid_rdata", rdata, 0);

    // Back-to-back lw, sw, lw with req_valid held high throughout.
    b2b_we[0] = 0; b2b_addr[0] = 32'h10; b2b_data[0] = 32'h0;
    b2b_we[1] = 1; b2b_addr[1] = 32'h24; b2b_data[1] = $urandom;
    b2b_we[2] = 0; b2b_addr[2] = 32'h24; b2b_data[2] = 32'h0;
    @(negedge clk);
    drive(b2b_we[0], 2'b10, 0, b2b_addr[0], b2b_data[0]);
    ref_apply(b2b_we[0], 2'b10, 0, b2b_addr[0], b2b_data[0], e, l);
    nresp = 0;
    busy_bad = 0;
    for (int c = 0; c < 30 && nresp < 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        check_val("b2b_err", resp_err, 0);
        check_val("b2b_rdata", rdata, exp_rdata);
        nresp++;
        if (nresp < 3) begin
          drive(b2b_we[nresp], 2'b10, 0, b2b_addr[nresp], b2b_data[nresp]);
          ref_apply(b2b_we[nresp], 2'b10, 0, b2b_addr[nresp], b2b_data[nresp], e, l);
        end else begin
          req_valid = 1'b0;
        end
      end else if (req_ready) begin
        busy_bad++;
      end
    end
    req_valid = 1'b0;
    check_val("b2b_nresp", nresp, 3);
    check_val("b2b_busy_ready", busy_bad, 0);
    check_val("b2b_word9", storage[9], b2b_data[1]);
    check_val("b2b_lw_val", rdata, b2b_data[1]);
    @(negedge clk);
    check_val("b2b_pulse", resp_valid, 0);

    // Random traffic, mostly in range and aligned, with occasional faults.
    for (int n = 0; n < 150; n++) begin
      logic        rwe, runs;
      logic [1:0]  rsize;
      logic [31:0] raddr;
      int          sel;
      rwe   = 1'($urandom);
      runs  = 1'($urandom);
      rsize = 2'($urandom_range(0, 3));
      sel   = $urandom_range(0, 9);
      if (sel == 0) raddr = $urandom;
      else if (sel == 1) raddr = 32'h100 + $urandom_range(0, 255);
      else begin
        raddr = $urandom_range(0, 255);
        if (sel > 3 && rsize != 2'b11) raddr = raddr & ~((32'h1 << rsize) - 1);
      end
      do_req("rnd", rwe, rsize, runs, raddr, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
